// File: rtl/coherence_home_responder.sv
// MSI directory home node: serializes cache misses and issues fetch/invalidate before replying.
// Optional HOME_PROTOCOL_ERR_EN: pulse protocolErr on a stale writeBack or reserved request type.
module coherence_home_responder #(
  parameter int NODES  = 2,
  parameter int ADDR_W = 2,
  localparam int NW    = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [1:0]        reqType,
  input  logic [NW-1:0]     reqNode,
  input  logic [ADDR_W-1:0] reqAddr,
  output logic              fetchValid,
  output logic [NW-1:0]     fetchNode,
  input  logic              fetchAck,
  output logic              invValid,
  output logic [NODES-1:0]  invMask,
  input  logic              invAck,
  output logic              replyValid,
  output logic [NW-1:0]     replyNode,
  input  logic              replyReady,
  output logic [1:0]        currentState,
  output logic [NODES-1:0]  sharers,
  output logic              protocolErr
);
  typedef enum logic [1:0] {IDLE, FETCH, INVAL, REPLY} fsm_t;
  localparam logic [1:0] ST_I = 2'b00, ST_S = 2'b01, ST_M = 2'b10;
  localparam logic [1:0] RD = 2'b00, WR = 2'b01, WB = 2'b10;
  localparam int ENTRIES = 2**ADDR_W;

  fsm_t                          state;
  logic [ENTRIES-1:0][1:0]       dir_st;
  logic [ENTRIES-1:0][NODES-1:0] dir_sh;
  logic [1:0]                    l_type;
  logic [NW-1:0]                 l_node;
  logic [ADDR_W-1:0]             l_addr;
  logic [1:0]                    e_st, ack_st;
  logic [NODES-1:0]              e_sh, req_oh, l_oh, inv_mask, ack_sh;
  logic [NW-1:0]                 owner;

  assign reqReady = (state == IDLE);
  assign e_st     = dir_st[reqAddr];
  assign e_sh     = dir_sh[reqAddr];
  assign req_oh   = NODES'(1) << reqNode;
  assign l_oh     = NODES'(1) << l_node;
  assign inv_mask = e_sh & ~req_oh;
  // Entry written when a fetch/invalidate completes: owner stays a sharer on a read.
  assign ack_st   = (l_type == RD) ? ST_S : ST_M;
  assign ack_sh   = (l_type == RD) ? (dir_sh[l_addr] | l_oh) : l_oh;

  always_comb begin
    owner = '0;
    for (int i = 0; i < NODES; i++)
      if (e_sh[i]) owner = NW'(i);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      dir_st       <= '0;
      dir_sh       <= '0;
      l_type       <= '0;
      l_node       <= '0;
      l_addr       <= '0;
      fetchValid   <= 1'b0;
      fetchNode    <= '0;
      invValid     <= 1'b0;
      invMask      <= '0;
      replyValid   <= 1'b0;
      replyNode    <= '0;
      currentState <= ST_I;
      sharers      <= '0;
    end else begin
      case (state)
        IDLE: if (reqValid) begin
          l_type       <= reqType;
          l_node       <= reqNode;
          l_addr       <= reqAddr;
          currentState <= e_st;
          sharers      <= e_sh;
          case (reqType)
            RD: begin
              if (e_st == ST_M && owner != reqNode) begin
                state <= FETCH; fetchValid <= 1'b1; fetchNode <= owner;
              end else begin
                state <= REPLY; replyValid <= 1'b1; replyNode <= reqNode;
                if (e_st != ST_M) begin
                  dir_st[reqAddr] <= ST_S; dir_sh[reqAddr] <= e_sh | req_oh;
                  currentState    <= ST_S; sharers         <= e_sh | req_oh;
                end
              end
            end
            WR: begin
              if (e_st == ST_M && owner != reqNode) begin
                state <= FETCH; fetchValid <= 1'b1; fetchNode <= owner;
              end else if (e_st == ST_S && inv_mask != '0) begin
                state <= INVAL; invValid <= 1'b1; invMask <= inv_mask;
              end else begin
                state <= REPLY; replyValid <= 1'b1; replyNode <= reqNode;
                dir_st[reqAddr] <= ST_M; dir_sh[reqAddr] <= req_oh;
                currentState    <= ST_M; sharers         <= req_oh;
              end
            end
            WB: if (e_st == ST_M && owner == reqNode) begin
              dir_st[reqAddr] <= ST_I; dir_sh[reqAddr] <= '0;
              currentState    <= ST_I; sharers         <= '0;
            end
            default: ;
          endcase
        end
        FETCH: if (fetchAck) begin
          state      <= REPLY;
          fetchValid <= 1'b0;
          fetchNode  <= '0;
          replyValid <= 1'b1;
          replyNode  <= l_node;
          dir_st[l_addr] <= ack_st; dir_sh[l_addr] <= ack_sh;
          currentState   <= ack_st; sharers        <= ack_sh;
        end
        INVAL: if (invAck) begin
          state      <= REPLY;
          invValid   <= 1'b0;
          invMask    <= '0;
          replyValid <= 1'b1;
          replyNode  <= l_node;
          dir_st[l_addr] <= ST_M; dir_sh[l_addr] <= l_oh;
          currentState   <= ST_M; sharers        <= l_oh;
        end
        REPLY: if (replyReady) begin
          state      <= IDLE;
          replyValid <= 1'b0;
          replyNode  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HOME_PROTOCOL_ERR_EN
  logic bad_req;
  assign bad_req = (reqType == 2'b11) ||
                   (reqType == WB && !(e_st == ST_M && owner == reqNode));
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) protocolErr <= 1'b0;
    else         protocolErr <= reqValid && reqReady && bad_req;
`else
  assign protocolErr = 1'b0;
`endif
endmodule

// File: doc/coherence_home_responder.md
# coherence_home_responder

Home-node responder for the directory-based MSI coherence protocol: the directory-side end of the cache-block message interface. Accepts readMiss/writeMiss/writeBack requests from up to NODES caches, keeps per-block directory state plus sharer vector, issues fetch and invalidate requests to remote caches, waits for their acknowledgements, then returns a data value reply. It sits between the cache-block controllers and memory. Its state and sharer outputs drive the existing board seven-segment and LED decoding.

## Interface
- NODES, 2, cache count; sharer-vector width; NW = $clog2(NODES)
- ADDR_W, 2, block index width; 2**ADDR_W directory entries
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- reqValid / reqReady  in / out  1 / 1  request handshake
- reqType  in  2  00 readMiss, 01 writeMiss, 10 writeBack, 11 reserved
- reqNode  in  NW  requesting cache
- reqAddr  in  ADDR_W  block index
- fetchValid / fetchNode / fetchAck  out / out / in  1 / NW / 1  fetch data from owner
- invValid / invMask / invAck  out / out / in  1 / NODES / 1  invalidate sharers; one combined ack
- replyValid / replyNode / replyReady  out / out / in  1 / NW / 1  data value reply
- currentState  out  2  state of last-accepted entry: 00 I, 01 S, 10 M
- sharers  out  NODES  sharer vector of last-accepted entry
- protocolErr  out  1  one-cycle pulse on illegal request

## Operation
- FSM states: IDLE, FETCH, INVAL, REPLY. reqReady = (state == IDLE), combinational.
- Accept = reqValid & reqReady. On accept, latch type, node, addr. Decide from entry E = dir[reqAddr]; owner = index of the single set bit of E.sharers.
- readMiss, E = I or S: next REPLY; at accept E <= {S, sharers | node}.
- readMiss, E = M, owner != node: next FETCH (fetchNode = owner). On fetchAck: E <= {S, owner | node}, then REPLY.
- readMiss, E = M, owner == node: next REPLY, E unchanged.
- writeMiss, E = I: E <= {M, node}, next REPLY.
- writeMiss, E = S: mask = sharers & ~node. If mask == 0: E <= {M, node}, next REPLY. Otherwise next INVAL with invMask = mask; on invAck: E <= {M, node}, then REPLY.
- writeMiss, E = M, owner != node: next FETCH. On fetchAck: E <= {M, node}, then REPLY. Owner == node: next REPLY, E unchanged.
- writeBack, E = M and owner == node: E <= {I, 0}. Stays IDLE. No reply.
- writeBack otherwise (stale), or reqType 11: E unchanged, stays IDLE, no reply, error handling per Configuration.
- REPLY: replyValid = 1, replyNode = latched node. Held until replyReady is sampled high, then IDLE.
- currentState/sharers are registered. They show the post-update value of the latched entry: updated on the same edge as the directory write.

## Timing
- Reset (async assert, any state, including mid-transaction): all entries {I, 0}. FSM IDLE. All valid outputs 0, fetchNode/replyNode/invMask 0, currentState 00, sharers 0, protocolErr 0. Abandoned handshakes are not resumed.
- Request-to-reply latency (no remote action): replyValid rises on the edge after accept; earliest new accept is 1 cycle after the replyReady handshake.
- fetchValid/invValid rise on the edge after accept and stay high until the ack is sampled. The ack edge updates the directory, drops valid and enters REPLY.
- Acks sampled only in their own state; fetchAck/invAck in any other state are ignored.
- writeBack occupies 1 cycle; reqReady stays high, so back-to-back accepts are legal.
- Requests to different addresses are serialized: one transaction outstanding.

## Configuration
- HOME_PROTOCOL_ERR_EN defined: stale writeBack or reqType 11 produces a 1-cycle protocolErr pulse on the edge after accept.
- Undefined: protocolErr tied 0. The request is still silently consumed. All other behaviour is identical.

## Test plan
- Reset, then readMiss node0 addr1 -> replyValid next cycle, replyNode 0, currentState 01, sharers 01.
- Node0 and node1 share addr1 (S, 11), then writeMiss node1 -> invValid with invMask 01; invAck -> replyValid to node1, state 10, sharers 10.
- Addr2 M owned by node0, readMiss node1 -> fetchValid with fetchNode 0, held 3 cycles without ack; fetchAck -> reply to node1, state 01, sharers 11.
- Addr2 M owned by node1, writeBack node1 -> state 00, sharers 00, no replyValid; a stale writeBack node0 to addr3 (I) -> protocolErr pulse only with HOME_PROTOCOL_ERR_EN.
- replyReady held low 4 cycles -> replyValid held and reqReady 0 throughout; a new reqValid is not accepted until after the handshake.
- resetn pulsed while in INVAL -> all outputs 0 immediately, entries I, reqReady 1 after release.
